// File: rtl/vc_out_sched.sv
// Packet-atomic output scheduler: NumVc virtual channels share one link, one whole packet at a time.
// Build option: define VC_OUT_SCHED_FIXED_PRIO_EN for fixed priority (highest index wins) instead of round-robin.
module vc_out_sched #(
    parameter int unsigned NumVc = 3,
    parameter int unsigned VcW   = $clog2(NumVc)
) (
    input  logic             clk,
    input  logic             arst,
    input  logic [NumVc-1:0] vc_valid_i,
    input  logic [NumVc-1:0] vc_head_i,
    input  logic [NumVc-1:0] vc_tail_i,
    output logic [NumVc-1:0] vc_ready_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [VcW-1:0]   out_vc_o,
    output logic             busy_o
);

    localparam int unsigned IdxW = VcW + 1;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t           r_state;
    logic [VcW-1:0]   r_grant;
    logic [NumVc-1:0] w_cand;
    logic             w_any;
    logic [VcW-1:0]   w_win;
    logic             w_hs;
    logic             w_tail_hs;

    // Only packet heads may claim an idle link.
    assign w_cand = vc_valid_i & vc_head_i;
    assign w_any  = |w_cand;

`ifdef VC_OUT_SCHED_FIXED_PRIO_EN
    always_comb begin
        w_win = '0;
        for (int unsigned i = 0; i < NumVc; i++) begin
            if (w_cand[i]) begin
                w_win = VcW'(i);
            end
        end
    end
`else
    logic [VcW-1:0]  r_ptr;
    logic [IdxW-1:0] w_idx;
    logic [VcW-1:0]  w_sel;
    logic            w_found;
    logic [VcW-1:0]  w_ptr_next;

    // Scan upward from the pointer, wrapping modulo NumVc (never produces index NumVc).
    always_comb begin
        w_win   = r_ptr;
        w_found = 1'b0;
        w_idx   = '0;
        w_sel   = '0;
        for (int unsigned i = 0; i < NumVc; i++) begin
            w_idx = IdxW'(r_ptr) + IdxW'(i);
            if (w_idx >= IdxW'(NumVc)) begin
                w_idx = w_idx - IdxW'(NumVc);
            end
            w_sel = VcW'(w_idx);
            if (!w_found && w_cand[w_sel]) begin
                w_win   = w_sel;
                w_found = 1'b1;
            end
        end
    end

    assign w_ptr_next = (r_grant == VcW'(NumVc - 1)) ? '0 : r_grant + VcW'(1);

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            r_ptr <= '0;
        end else if (w_tail_hs) begin
            r_ptr <= w_ptr_next;
        end
    end
`endif

    assign busy_o      = (r_state == ST_LOCKED);
    assign out_vc_o    = r_grant;
    // out_valid_o deliberately excludes out_ready_i.
    assign out_valid_o = busy_o & vc_valid_i[r_grant];
    assign w_hs        = out_valid_o & out_ready_i;
    assign w_tail_hs   = w_hs & vc_tail_i[r_grant];

    always_comb begin
        vc_ready_o          = '0;
        vc_ready_o[r_grant] = w_hs;
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_grant <= w_win;
                        r_state <= ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (w_tail_hs) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vc_out_sched.sv
// Scoreboard bench for vc_out_sched (NumVc=3); honours VC_OUT_SCHED_FIXED_PRIO_EN for expected order.
`timescale 1ns/1ps
module tb_vc_out_sched;

    typedef struct {
        logic head;
        logic tail;
        int   id;
    } flit_t;

    typedef struct {
        int vc;
        int id;
    } exp_t;

    logic       clk = 1'b0;
    logic       arst;
    logic [2:0] vc_valid_i;
    logic [2:0] vc_head_i;
    logic [2:0] vc_tail_i;
    logic [2:0] vc_ready_o;
    logic       out_valid_o;
    logic       out_ready_i;
    logic [1:0] out_vc_o;
    logic       busy_o;

    flit_t q0[$];
    flit_t q1[$];
    flit_t q2[$];
    exp_t  exp_q[$];
    int    hs_cyc[$];
    int    cyc = 0;
    int    vectors = 0;
    int    miscompares = 0;

    always #5 clk = ~clk;

    vc_out_sched #(.NumVc(3)) dut (
        .clk        (clk),
        .arst       (arst),
        .vc_valid_i (vc_valid_i),
        .vc_head_i  (vc_head_i),
        .vc_tail_i  (vc_tail_i),
        .vc_ready_o (vc_ready_o),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .out_vc_o   (out_vc_o),
        .busy_o     (busy_o)
    );

    function automatic int qsize(int vc);
        case (vc)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic flit_t qfront(int vc);
        case (vc)
            0:       return q0[0];
            1:       return q1[0];
            default: return q2[0];
        endcase
    endfunction

    task automatic push_flit(input int vc, input logic h, input logic t, input int id);
        flit_t f;
        f.head = h;
        f.tail = t;
        f.id   = id;
        case (vc)
            0:       q0.push_back(f);
            1:       q1.push_back(f);
            default: q2.push_back(f);
        endcase
    endtask

    task automatic pop_flit(input int vc);
        case (vc)
            0:       void'(q0.pop_front());
            1:       void'(q1.pop_front());
            default: void'(q2.pop_front());
        endcase
    endtask

    task automatic expect_flit(input int vc, input int id);
        exp_t e;
        e.vc = vc;
        e.id = id;
        exp_q.push_back(e);
    endtask

    // Packet of len flits, ids id0..id0+len-1; stimulus only, expectations pushed separately.
    task automatic push_pkt(input int vc, input int len, input int id0);
        for (int k = 0; k < len; k++) begin
            push_flit(vc, logic'(k == 0), logic'(k == len - 1), id0 + k);
        end
    endtask

    task automatic expect_pkt(input int vc, input int len, input int id0);
        for (int k = 0; k < len; k++) begin
            expect_flit(vc, id0 + k);
        end
    endtask

    task automatic drive_inputs();
        logic [2:0] v;
        logic [2:0] h;
        logic [2:0] t;
        flit_t      f;
        v = '0;
        h = '0;
        t = '0;
        for (int i = 0; i < 3; i++) begin
            if (qsize(i) > 0) begin
                f    = qfront(i);
                v[i] = 1'b1;
                h[i] = f.head;
                t[i] = f.tail;
            end
        end
        vc_valid_i = v;
        vc_head_i  = h;
        vc_tail_i  = t;
    endtask

    // One clock: check at negedge, pop accepted flit after posedge, re-drive VC heads.
    task automatic step();
        logic       hs;
        int         vc;
        exp_t       e;
        flit_t      f;
        logic [2:0] exp_rdy;
        @(negedge clk);
        hs      = out_valid_o && out_ready_i;
        vc      = int'(out_vc_o);
        exp_rdy = hs ? 3'(1 << vc) : 3'b000;
        vectors++;
        if (vc_ready_o !== exp_rdy) begin
            miscompares++;
            $display("FAIL ready_strobe cyc=%0d: vc_ready_o=%b expected %b", cyc, vc_ready_o, exp_rdy);
        end
        if (hs) begin
            hs_cyc.push_back(cyc);
            vectors++;
            if (exp_q.size() == 0 || qsize(vc) == 0) begin
                miscompares++;
                $display("FAIL unexpected_flit cyc=%0d: transfer on vc%0d, expected none", cyc, vc);
            end else begin
                e = exp_q.pop_front();
                f = qfront(vc);
                if (vc !== e.vc || f.id !== e.id) begin
                    miscompares++;
                    $display("FAIL flit_order cyc=%0d: got vc%0d id%0d, expected vc%0d id%0d",
                             cyc, vc, f.id, e.vc, e.id);
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (hs && qsize(vc) > 0) pop_flit(vc);
        drive_inputs();
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            step();
            n++;
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain_timeout: %0d flits outstanding, expected 0", exp_q.size());
        end
    endtask

    task automatic pulse_reset();
        arst = 1'b0;
        @(posedge clk);
        #1;
        arst = 1'b1;
        drive_inputs();
    endtask

    task automatic test_reset();
        arst        = 1'b0;
        out_ready_i = 1'b0;
        vc_valid_i  = '0;
        vc_head_i   = '0;
        vc_tail_i   = '0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({out_valid_o, vc_ready_o, busy_o, out_vc_o} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: {valid,ready,busy,vc}=%b expected 0", {out_valid_o, vc_ready_o, busy_o, out_vc_o});
        end
        arst = 1'b1;
        @(negedge clk);
        vectors++;
        if ({out_valid_o, vc_ready_o, busy_o, out_vc_o} !== 7'b0) begin
            miscompares++;
            $display("FAIL post_release_idle: {valid,ready,busy,vc}=%b expected 0", {out_valid_o, vc_ready_o, busy_o, out_vc_o});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_flit();
        out_ready_i = 1'b1;
        push_flit(1, 1'b1, 1'b1, 10);
        expect_flit(1, 10);
        drive_inputs();
        vectors++;
        if (busy_o !== 1'b0 || out_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL single_arb_cycle: busy=%b valid=%b expected 0 0", busy_o, out_valid_o);
        end
        step();
        vectors++;
        if (busy_o !== 1'b1 || out_vc_o !== 2'd1 || out_valid_o !== 1'b1) begin
            miscompares++;
            $display("FAIL single_locked: busy=%b vc=%0d valid=%b expected 1 1 1", busy_o, out_vc_o, out_valid_o);
        end
        step();
        vectors++;
        if (busy_o !== 1'b0 || out_valid_o !== 1'b0 || out_vc_o !== 2'd1) begin
            miscompares++;
            $display("FAIL single_back_idle: busy=%b valid=%b vc=%0d expected 0 0 1", busy_o, out_valid_o, out_vc_o);
        end
    endtask

    // Pointer sits at 2 after the single VC1 packet; VC2's tail wraps it to 0.
    task automatic test_wrap();
        push_flit(0, 1'b1, 1'b1, 20);
        push_flit(2, 1'b1, 1'b1, 21);
        push_flit(2, 1'b1, 1'b1, 22);
`ifdef VC_OUT_SCHED_FIXED_PRIO_EN
        expect_flit(2, 21);
        expect_flit(2, 22);
        expect_flit(0, 20);
`else
        expect_flit(2, 21);
        expect_flit(0, 20);
        expect_flit(2, 22);
`endif
        drive_inputs();
        drain(30);
    endtask

    task automatic test_no_interleave();
        int exp_gap[5] = '{1, 1, 2, 1, 1};
        pulse_reset();
        hs_cyc.delete();
        push_pkt(0, 3, 30);
        push_pkt(2, 3, 40);
`ifdef VC_OUT_SCHED_FIXED_PRIO_EN
        expect_pkt(2, 3, 40);
        expect_pkt(0, 3, 30);
`else
        expect_pkt(0, 3, 30);
        expect_pkt(2, 3, 40);
`endif
        drive_inputs();
        drain(40);
        vectors++;
        if (hs_cyc.size() != 6) begin
            miscompares++;
            $display("FAIL interleave_count: %0d transfers, expected 6", hs_cyc.size());
        end else begin
            for (int i = 1; i < 6; i++) begin
                vectors++;
                if (hs_cyc[i] - hs_cyc[i-1] != exp_gap[i-1]) begin
                    miscompares++;
                    $display("FAIL interleave_gap[%0d]: %0d cycles, expected %0d", i, hs_cyc[i] - hs_cyc[i-1], exp_gap[i-1]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        out_ready_i = 1'b1;
        push_pkt(1, 3, 50);
        expect_pkt(1, 3, 50);
        drive_inputs();
        step();
        step();
        out_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if (out_valid_o !== 1'b1 || vc_ready_o !== 3'b000 || busy_o !== 1'b1 || out_vc_o !== 2'd1) begin
                miscompares++;
                $display("FAIL backpressure[%0d]: valid=%b ready=%b busy=%b vc=%0d expected 1 000 1 1",
                         i, out_valid_o, vc_ready_o, busy_o, out_vc_o);
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        out_ready_i = 1'b1;
        drain(20);
    endtask

    task automatic test_body_only();
        push_flit(0, 1'b0, 1'b1, 60);
        drive_inputs();
        for (int i = 0; i < 6; i++) begin
            step();
            vectors++;
            if (busy_o !== 1'b0 || vc_ready_o[0] !== 1'b0) begin
                miscompares++;
                $display("FAIL body_only[%0d]: busy=%b ready0=%b expected 0 0", i, busy_o, vc_ready_o[0]);
            end
        end
        q0.delete();
        drive_inputs();
    endtask

    task automatic test_reset_mid_packet();
        out_ready_i = 1'b1;
        push_pkt(2, 3, 70);
        expect_flit(2, 70);
        drive_inputs();
        step();
        step();
        vectors++;
        if (busy_o !== 1'b1 || out_vc_o !== 2'd2) begin
            miscompares++;
            $display("FAIL mid_packet_lock: busy=%b vc=%0d expected 1 2", busy_o, out_vc_o);
        end
        #2;
        arst = 1'b0;
        #1;
        vectors++;
        if ({out_valid_o, vc_ready_o, busy_o, out_vc_o} !== 7'b0) begin
            miscompares++;
            $display("FAIL async_reset: {valid,ready,busy,vc}=%b expected 0", {out_valid_o, vc_ready_o, busy_o, out_vc_o});
        end
        q2.delete();
        exp_q.delete();
        @(posedge clk);
        #1;
        arst = 1'b1;
        push_flit(1, 1'b1, 1'b1, 80);
        push_flit(2, 1'b1, 1'b1, 81);
`ifdef VC_OUT_SCHED_FIXED_PRIO_EN
        expect_flit(2, 81);
        expect_flit(1, 80);
`else
        expect_flit(1, 80);
        expect_flit(2, 81);
`endif
        drive_inputs();
        drain(20);
    endtask

`ifdef VC_OUT_SCHED_FIXED_PRIO_EN
    task automatic test_fixed_prio();
        for (int v = 0; v < 3; v++) begin
            push_flit(v, 1'b1, 1'b1, 90 + 2 * v);
            push_flit(v, 1'b1, 1'b1, 91 + 2 * v);
        end
        for (int v = 2; v >= 0; v--) begin
            expect_flit(v, 90 + 2 * v);
            expect_flit(v, 91 + 2 * v);
        end
        drive_inputs();
        drain(40);
    endtask
`endif

    initial begin
        test_reset();
        test_single_flit();
        test_wrap();
        test_no_interleave();
        test_backpressure();
        test_body_only();
        test_reset_mid_packet();
`ifdef VC_OUT_SCHED_FIXED_PRIO_EN
        test_fixed_prio();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded 200000 ns, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/vc_out_sched.md
VC_OUT_SCHED -- requirements
Module: vc_out_sched

Interface
REQ-001 SHALL have parameter NumVc, default 3, number of virtual channels sharing one output link (2..8).
REQ-002 SHALL have derived parameter VcW, default $clog2(NumVc), width of the VC index.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port arst, input, 1, reset, asynchronous assert, active-low.
REQ-005 SHALL have port vc_valid_i, input, NumVc, per-VC flit available at the VC buffer head.
REQ-006 SHALL have port vc_head_i, input, NumVc, per-VC head-flit marker, qualified by vc_valid_i.
REQ-007 SHALL have port vc_tail_i, input, NumVc, per-VC tail-flit marker, qualified by vc_valid_i; head and tail both set marks a single-flit packet.
REQ-008 SHALL have port vc_ready_o, output, NumVc, per-VC pop strobe back to the VC buffers.
REQ-009 SHALL have port out_valid_o, output, 1, flit valid toward the output link.
REQ-010 SHALL have port out_ready_i, input, 1, output link accepts the flit.
REQ-011 SHALL have port out_vc_o, output, VcW, index of the VC currently owning the link (flit mux select).
REQ-012 SHALL have port busy_o, output, 1, high while a packet holds the link.

Function
REQ-013 SHALL implement a two-state FSM: IDLE and LOCKED.
REQ-014 IDLE: candidates are VCs with vc_valid_i=1 and vc_head_i=1; VCs with valid but no head SHALL NOT be candidates.
REQ-015 IDLE with at least one candidate: SHALL register the winner into the grant index and enter LOCKED next cycle (1-cycle arbitration latency; no flit transfer in IDLE).
REQ-016 IDLE: out_valid_o=0, vc_ready_o=0, busy_o=0; out_vc_o holds the last granted index.
REQ-017 LOCKED: out_valid_o=vc_valid_i[g]; vc_ready_o[g]=out_ready_i and vc_valid_i[g]; all other vc_ready_o bits 0; busy_o=1; out_vc_o=g.
REQ-018 Handshake: out_valid_o and out_ready_i in the same cycle; a flit transfers only on a handshake.
REQ-019 LOCKED: a handshake with vc_tail_i[g]=1 SHALL return to IDLE next cycle and set the round-robin pointer to (g+1) mod NumVc.
REQ-020 LOCKED: a deasserted vc_valid_i[g] mid-packet SHALL hold LOCKED; grant stays on g with no timeout.
REQ-021 LOCKED: valid/head activity on other VCs SHALL be ignored until the tail handshake.
REQ-022 Round-robin: the winner is the first candidate found scanning from the pointer upward with wrap-around past NumVc-1 to 0.
REQ-023 Pointer arithmetic SHALL be modulo NumVc, also for non-power-of-2 NumVc; index NumVc never produced.
REQ-024 No combinational path from out_ready_i to out_valid_o; out_valid_o depends only on state and vc_valid_i.

Reset
REQ-025 arst low SHALL immediately force state IDLE, grant index 0, RR pointer 0; outputs out_valid_o=0, vc_ready_o=0, busy_o=0, out_vc_o=0.
REQ-026 Reset mid-packet SHALL abandon the lock; after release, arbitration restarts from pointer 0.
REQ-027 Release of arst SHALL take effect on the first rising clk edge with arst high.

Configuration
REQ-028 Macro VC_OUT_SCHED_FIXED_PRIO_EN defined: IDLE arbitration SHALL be fixed priority, highest index wins; the RR pointer is removed.
REQ-029 Macro undefined: round-robin per REQ-019/REQ-022; all other behaviour identical in both builds.

Verification (NumVc=3, round-robin build unless stated)
REQ-030 Reset, then VC1 sends a single flit with head=tail=1 and out_ready_i=1 -> LOCKED 1 cycle after the request, one handshake, IDLE next cycle, pointer=2.
REQ-031 VC0 and VC2 both present heads from pointer 0, each with a 3-flit packet -> VC0 packet fully transferred, then 1 idle cycle, then VC2; no interleaving.
REQ-032 VC1 locked with out_ready_i low for 5 cycles mid-packet -> out_valid_o stays 1, vc_ready_o=000, no flit lost; resumes when ready returns.
REQ-033 VC2 granted, tail handshake with pointer wrapping to 0 while VC0 and VC2 request -> VC0 wins next.
REQ-034 VC0 presents a body flit (head=0) in IDLE -> never granted, vc_ready_o[0]=0.
REQ-035 FIXED_PRIO build, VC0..VC2 all request repeatedly -> VC2 wins every arbitration; arst pulsed mid-packet -> outputs 0 immediately, busy_o=0.
